simple_ff_pipe: RTL and testbench
=================================

Name: simple_ff_pipe

Overview:
Parametrised elastic register pipeline. It is the multi-bit, multi-stage successor to the single clock-enabled flop. It carries WIDTH-bit data through DEPTH registered stages using a valid/ready handshake, so back-pressure stalls only the stages that must stall, and bubbles collapse. It is used wherever the design needs retiming stages that stay correct under stall: bus slicing, crossing long routes, and cutting timing paths.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 4, number of register stages (>=1)
RESET_VAL, '0, WIDTH-bit value loaded into every data register on reset
DATA_RESET, "TRUE", "TRUE": data registers use async reset; "FALSE": only valid bits and LEVEL are reset, data registers have no reset

Ports:
CK  input  1  clock, all state updates on the rising edge
SR_N  input  1  asynchronous active-low reset
CLR  input  1  synchronous flush, active high
IN_VALID  input  1  upstream data valid
IN_READY  output  1  pipeline accepts D this cycle
D  input  WIDTH  upstream data
OUT_VALID  output  1  Q holds valid data
OUT_READY  input  1  downstream accepts Q this cycle
Q  output  WIDTH  data from the last stage
LEVEL  output  $clog2(DEPTH+1)  number of occupied stages, 0..DEPTH

Behaviour:
- Clock and reset: one clock, CK. Reset is asynchronous and active-low on SR_N.
- Stage state: stage i (0..DEPTH-1) holds valid bit v[i] and data register d[i]. Q = d[DEPTH-1]; OUT_VALID = v[DEPTH-1].
- Reset (SR_N low, asynchronous, no clock needed):
  - all v[i]=0, LEVEL=0, OUT_VALID=0.
  - If DATA_RESET="TRUE": d[i]=RESET_VAL, so Q=RESET_VAL.
  - If DATA_RESET="FALSE": Q is X until the first item reaches the last stage.
  - IN_READY is forced 0 while SR_N is low.
  - Release is synchronous-safe: the first accept can occur on the first CK edge with SR_N high.
- Ready chain (combinational, no added latency):
  - r[DEPTH] = OUT_READY
  - r[i] = !v[i] | r[i+1]
  - IN_READY = r[0] & SR_N
- Stage load: on a CK edge, stage i loads from stage i-1 (stage 0 loads from D/IN_VALID) when r[i]=1.
  - v[i] <= v[i-1] (IN_VALID for i=0)
  - d[i] <= source data only when the source is valid; otherwise d[i] is held, so there are no spurious data toggles.
  - When r[i]=0, the stage holds.
- Transfers and throughput:
  - in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY.
  - Full throughput: one item per cycle with OUT_READY held high.
  - Latency: an item accepted at edge n appears with OUT_VALID=1 after edge n+DEPTH-1 (visible in cycle n+DEPTH) when unstalled.
- Bubble collapse: with OUT_READY=0, empty stages keep accepting until all DEPTH stages are full. IN_READY then goes 0.
- Ordering: strict FIFO order, no drop, no duplication.
- Full pipeline with OUT_READY=1: IN_READY=1, simultaneous in/out fire, LEVEL unchanged.
- LEVEL: registered counter.
  - +1 on in_fire only, -1 on out_fire only, unchanged on both or neither.
  - Must always equal the popcount of v[]. It never exceeds DEPTH and never underflows.
- CLR (synchronous, dominant):
  - At the edge where CLR=1: all v[i] <= 0, LEVEL <= 0, and any in_fire that cycle is discarded.
  - Data registers are not modified.
  - IN_READY is not gated by CLR.
  - OUT_VALID is 0 from the next cycle.
- DEPTH=1: a single skid-free register slice. IN_READY = !v[0] | OUT_READY.
- Reset mid-operation: all in-flight items are lost, outputs return to their reset values immediately, and no partial transfer is reported.
- D is never sampled into a stage without IN_VALID=1 at that stage's load.

Test Plan:
- Reset: WIDTH=8, DEPTH=4, RESET_VAL=8'hA5, drive SR_N low mid-cycle -> immediately OUT_VALID=0, Q=8'hA5, LEVEL=0, IN_READY=0. Release SR_N -> IN_READY=1 in the same cycle.
- Streaming: OUT_READY=1, push 0x01..0x10 on consecutive cycles -> first OUT_VALID 4 cycles after the first accept, outputs 0x01..0x10 in order with no gaps, LEVEL steady at 4.
- Back-pressure fill: OUT_READY=0, IN_VALID=1 with 0x11,0x22,0x33,0x44,0x55 -> 4 accepted, IN_READY=0 thereafter, LEVEL=4. Raise OUT_READY -> 0x11 out, 0x55 accepted in the same cycle, LEVEL stays 4.
- Bubbles: IN_VALID toggling 1,0,1,0 with OUT_READY pulsed randomly -> scoreboard order matches, LEVEL equals the count of valid stages every cycle.
- CLR: LEVEL=3, assert CLR for one cycle with IN_VALID=1 -> next cycle LEVEL=0, OUT_VALID=0, the input item is not later emitted.
- DATA_RESET="FALSE", DEPTH=1: reset -> OUT_VALID=0, Q=X permitted. Push 0x7E -> next cycle OUT_VALID=1, Q=0x7E. Hold OUT_READY=0 -> IN_READY=0.

Source files
------------

// File: rtl/simple_ff_pipe.sv
// Elastic valid/ready register pipeline: WIDTH-bit data through DEPTH stages.
// Back-pressure stalls only the stages that must stall, and bubbles collapse.
module simple_ff_pipe #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter string            DATA_RESET = "TRUE"
) (
    input  logic                       CK,
    input  logic                       SR_N,
    input  logic                       CLR,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [WIDTH-1:0]           D,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [WIDTH-1:0]           Q,
    output logic [$clog2(DEPTH+1)-1:0] LEVEL
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] LEVEL_ONE = LW'(1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [LW-1:0]    level_q, level_d;
    logic             in_fire;
    logic             out_fire;

    // A stage may load when it is empty or the stage after it is moving.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = OUT_READY;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !v_q[i] | rdy[i+1];
        end
    end

    assign IN_READY  = rdy[0] & SR_N;
    assign OUT_VALID = v_q[DEPTH-1];
    assign Q         = d_q[DEPTH-1];
    assign LEVEL     = level_q;
    assign in_fire   = IN_VALID & IN_READY;
    assign out_fire  = v_q[DEPTH-1] & OUT_READY;

    always_comb begin
        src_v[0] = IN_VALID;
        src_d[0] = D;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = v_q[i-1];
            src_d[i] = d_q[i-1];
        end
    end

    // Data only moves with a valid source, so idle stages never toggle.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (CLR) begin
                v_d[i] = 1'b0;
            end else if (rdy[i]) begin
                v_d[i] = src_v[i];
                if (src_v[i]) begin
                    d_d[i] = src_d[i];
                end
            end
        end
    end

    always_comb begin
        level_d = level_q;
        if (CLR) begin
            level_d = '0;
        end else if (in_fire && !out_fire) begin
            level_d = level_q + LEVEL_ONE;
        end else if (out_fire && !in_fire) begin
            level_d = level_q - LEVEL_ONE;
        end
    end

    always_ff @(posedge CK or negedge SR_N) begin
        if (!SR_N) begin
            v_q     <= '0;
            level_q <= '0;
        end else begin
            v_q     <= v_d;
            level_q <= level_d;
        end
    end

    generate
        if (DATA_RESET == "TRUE") begin : g_data_rst
            always_ff @(posedge CK or negedge SR_N) begin
                if (!SR_N) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        d_q[i] <= RESET_VAL;
                    end
                end else begin
                    d_q <= d_d;
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge CK) begin
                d_q <= d_d;
            end
        end
    endgenerate

endmodule

// File: tb/tb_simple_ff_pipe.sv
// Directed bench for simple_ff_pipe: a DEPTH=4 data-reset instance and a
// DEPTH=1 no-data-reset slice, sharing clock and reset.
module tb_simple_ff_pipe;

    logic       ck;
    logic       srN;
    logic       clrA, ivA, irdyA, ovA, ordyA;
    logic [7:0] dA, qA;
    logic [2:0] levA;
    logic       clrB, ivB, irdyB, ovB, ordyB;
    logic [7:0] dB, qB;
    logic [0:0] levB;

    int checks = 0;
    int errors = 0;

    simple_ff_pipe #(
        .WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5), .DATA_RESET("TRUE")
    ) dutA (
        .CK(ck), .SR_N(srN), .CLR(clrA), .IN_VALID(ivA), .IN_READY(irdyA),
        .D(dA), .OUT_VALID(ovA), .OUT_READY(ordyA), .Q(qA), .LEVEL(levA)
    );

    simple_ff_pipe #(
        .WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00), .DATA_RESET("FALSE")
    ) dutB (
        .CK(ck), .SR_N(srN), .CLR(clrB), .IN_VALID(ivB), .IN_READY(irdyB),
        .D(dB), .OUT_VALID(ovB), .OUT_READY(ordyB), .Q(qB), .LEVEL(levB)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
        ivA   = iv;
        dA    = d;
        ordyA = ordy;
        clrA  = clr;
    endtask

    task automatic applyStimulusSlice(input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
        ivB   = iv;
        dB    = d;
        ordyB = ordy;
        clrB  = clr;
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    initial begin
        logic [7:0]  fillData [5];
        logic [7:0]  drainQ   [4];
        logic [15:0] ordyPat;
        logic [7:0]  expQ [$];
        logic        iv, ordy, mRdy;

        fillData = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        drainQ   = '{8'h22, 8'h33, 8'h44, 8'h55};
        ordyPat  = 16'b1011_0010_1101_0110;

        srN = 1'b0;
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
        applyStimulusSlice(1'b1, 8'h00, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("rst_out_valid", ovA, 0);
        checkOutput("rst_q", qA, 32'hA5);
        checkOutput("rst_level", levA, 0);
        checkOutput("rst_in_ready", irdyA, 0);
        checkOutput("rst_b_out_valid", ovB, 0);
        checkOutput("rst_b_level", levB, 0);
        checkOutput("rst_b_in_ready", irdyB, 0);

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulusSlice(1'b0, 8'h00, 1'b0, 1'b0);
        srN = 1'b1;
        #1;
        checkOutput("release_in_ready", irdyA, 1);

        // DEPTH=1 slice
        tick();
        applyStimulusSlice(1'b1, 8'h7E, 1'b0, 1'b0);
        #1;
        checkOutput("b_in_ready_empty", irdyB, 1);
        tick();
        applyStimulusSlice(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        checkOutput("b_out_valid", ovB, 1);
        checkOutput("b_q", qB, 32'h7E);
        checkOutput("b_level", levB, 1);
        checkOutput("b_in_ready_full", irdyB, 0);
        tick();
        checkOutput("b_hold_q", qB, 32'h7E);
        checkOutput("b_hold_in_ready", irdyB, 0);
        applyStimulusSlice(1'b1, 8'h3C, 1'b1, 1'b0);
        #1;
        checkOutput("b_in_ready_pass", irdyB, 1);
        tick();
        applyStimulusSlice(1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        checkOutput("b_q2", qB, 32'h3C);
        checkOutput("b_level2", levB, 1);
        tick();
        checkOutput("b_drain_valid", ovB, 0);
        checkOutput("b_drain_level", levB, 0);
        checkOutput("b_drain_q_held", qB, 32'h3C);

        // Streaming 0x01..0x10 at full throughput
        for (int t = 0; t <= 20; t++) begin
            applyStimulus(t < 16, 8'(t + 1), 1'b1, 1'b0);
            #1;
            if (t < 16) checkOutput("stream_in_ready", irdyA, 1);
            checkOutput("stream_out_valid", ovA, (t >= 4 && t <= 19) ? 1 : 0);
            if (t >= 4 && t <= 19) checkOutput("stream_q", qA, t - 3);
            checkOutput("stream_level", levA, (t < 4) ? t : ((t <= 16) ? 4 : 20 - t));
            tick();
        end

        // Back-pressure fill, then release with simultaneous in/out
        for (int t = 0; t < 4; t++) begin
            applyStimulus(1'b1, fillData[t], 1'b0, 1'b0);
            #1;
            checkOutput("fill_in_ready", irdyA, 1);
            checkOutput("fill_level", levA, t);
            tick();
        end
        for (int t = 0; t < 2; t++) begin
            applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
            #1;
            checkOutput("full_in_ready", irdyA, 0);
            checkOutput("full_level", levA, 4);
            checkOutput("full_out_valid", ovA, 1);
            checkOutput("full_q", qA, 32'h11);
            tick();
        end
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        #1;
        checkOutput("full_pass_in_ready", irdyA, 1);
        checkOutput("full_pass_q", qA, 32'h11);
        tick();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            #1;
            checkOutput("drain_out_valid", ovA, 1);
            checkOutput("drain_q", qA, drainQ[k]);
            checkOutput("drain_level", levA, 4 - k);
            tick();
        end
        checkOutput("drain_empty_valid", ovA, 0);
        checkOutput("drain_empty_level", levA, 0);

        // Flush with an input offered in the same cycle
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 8'(8'h61 + k), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 8'h64, 1'b0, 1'b1);
        #1;
        checkOutput("clr_pre_level", levA, 3);
        checkOutput("clr_in_ready", irdyA, 1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        checkOutput("clr_level", levA, 0);
        checkOutput("clr_out_valid", ovA, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("clr_no_emit", ovA, 0);
        end
        checkOutput("clr_data_held", qA, 32'h55);

        // Bubbles under irregular back-pressure, checked against an in-order queue
        for (int t = 0; t < 24; t++) begin
            iv   = (t < 16) && (t % 2 == 0);
            ordy = (t < 16) ? ordyPat[t] : 1'b1;
            applyStimulus(iv, 8'(8'h80 + t), ordy, 1'b0);
            #1;
            mRdy = (expQ.size() < 4) || ordy;
            checkOutput("bub_level", levA, expQ.size());
            checkOutput("bub_in_ready", irdyA, mRdy);
            if (ovA && ordy) begin
                if (expQ.size() == 0) checkOutput("bub_extra_out", ovA, 0);
                else checkOutput("bub_order", qA, expQ.pop_front());
            end
            if (iv && mRdy) expQ.push_back(8'(8'h80 + t));
            tick();
        end
        checkOutput("bub_end_level", levA, 0);
        checkOutput("bub_end_valid", ovA, 0);

        // Reset asserted mid-cycle with a full pipeline
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 8'(8'h91 + k), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        checkOutput("pre_rst_level", levA, 4);
        checkOutput("pre_rst_q", qA, 32'h91);
        #2;
        srN = 1'b0;
        #1;
        checkOutput("midrst_out_valid", ovA, 0);
        checkOutput("midrst_q", qA, 32'hA5);
        checkOutput("midrst_level", levA, 0);
        checkOutput("midrst_in_ready", irdyA, 0);
        tick();
        srN = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("post_rst_no_emit", ovA, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
